// File: rtl/axi_route_pkg.sv
// Route-FIFO types shared by the AXI W-channel router.
// AXI_WDATA_BEAT_CHK_EN adds the burst length to every route entry.
package axi_route_pkg;

  localparam int ROUTE_SEL_W = 8;

  // Sink entries are normalised to all-ones so the head decode
  // does not depend on NUM_SLAVES.
  localparam logic [ROUTE_SEL_W-1:0] SINK_SEL = '1;

  typedef struct packed {
    logic [ROUTE_SEL_W-1:0] sel;
`ifdef AXI_WDATA_BEAT_CHK_EN
    logic [7:0]             len;
`endif
  } route_entry_t;

  function automatic int sel_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/axi_wdata_router_if.sv
// AW-decision, master W and slave W signals of the W-channel router.
// master: the bridge side driving the router; slave: the router itself.
interface axi_wdata_router_if
  import axi_route_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int DATA_W     = 32,
  parameter int STRB_W     = DATA_W / 8,
  parameter int SEL_W      = sel_width(NUM_SLAVES)
) ();

  logic                         aw_push;
  logic [SEL_W-1:0]             aw_sel;
  logic [7:0]                   aw_len;
  logic                         route_full;
  logic                         route_empty;

  logic [DATA_W-1:0]            m_wdata;
  logic [STRB_W-1:0]            m_wstrb;
  logic                         m_wlast;
  logic                         m_wvalid;
  logic                         m_wready;

  logic [NUM_SLAVES*DATA_W-1:0] s_wdata;
  logic [NUM_SLAVES*STRB_W-1:0] s_wstrb;
  logic [NUM_SLAVES-1:0]        s_wlast;
  logic [NUM_SLAVES-1:0]        s_wvalid;
  logic [NUM_SLAVES-1:0]        s_wready;

  logic                         err_wlast;

  modport master (
    output aw_push, aw_sel, aw_len,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    output s_wready,
    input  route_full, route_empty,
    input  m_wready,
    input  s_wdata, s_wstrb, s_wlast, s_wvalid,
    input  err_wlast
  );

  modport slave (
    input  aw_push, aw_sel, aw_len,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  s_wready,
    output route_full, route_empty,
    output m_wready,
    output s_wdata, s_wstrb, s_wlast, s_wvalid,
    output err_wlast
  );

endinterface

// File: rtl/axi_route_fifo.sv
// DEPTH-entry registered FIFO of route entries, no bypass.
// Full/empty come straight from the registered count.
module axi_route_fifo
  import axi_route_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  route_entry_t din,
  input  logic         pop,
  output route_entry_t dout,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  route_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = count == CNT_W'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axi_wdata_router.sv
// W-channel demux steered by an in-order FIFO of AW decisions.
// Define AXI_WDATA_BEAT_CHK_EN to end bursts on AWLEN and flag WLAST errors.
module axi_wdata_router
  import axi_route_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int DATA_W     = 32,
  parameter int STRB_W     = DATA_W / 8,
  parameter int DEPTH      = 4,
  parameter int SEL_W      = sel_width(NUM_SLAVES)
) (
  input logic               clk,
  input logic               rst,
  axi_wdata_router_if.slave bus
);

  route_entry_t push_entry;
  route_entry_t head;
  logic         is_sink;
  logic         hs;
  logic         burst_end;
  logic         pop;

  always_comb begin
    push_entry = '0;
    if (bus.aw_sel >= SEL_W'(NUM_SLAVES))
      push_entry.sel = SINK_SEL;
    else
      push_entry.sel = ROUTE_SEL_W'(bus.aw_sel);
`ifdef AXI_WDATA_BEAT_CHK_EN
    push_entry.len = bus.aw_len;
`endif
  end

  axi_route_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.aw_push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (bus.route_full),
    .empty (bus.route_empty)
  );

  assign is_sink = head.sel == SINK_SEL;

  // Data and last are broadcast; only valid and strobe are steered.
  assign bus.s_wdata = {NUM_SLAVES{bus.m_wdata}};
  assign bus.s_wlast = {NUM_SLAVES{bus.m_wlast}};

  always_comb begin
    bus.s_wvalid = '0;
    bus.s_wstrb  = '1;
    bus.m_wready = 1'b0;
    if (!bus.route_empty) begin
      if (is_sink)
        bus.m_wready = 1'b1;
      for (int k = 0; k < NUM_SLAVES; k++) begin
        if (head.sel == ROUTE_SEL_W'(k)) begin
          bus.s_wvalid[k]                 = bus.m_wvalid;
          bus.s_wstrb[k*STRB_W +: STRB_W] = bus.m_wstrb;
          bus.m_wready                    = bus.s_wready[k];
        end
      end
    end
  end

  assign hs  = bus.m_wvalid & bus.m_wready;
  assign pop = hs & burst_end;

`ifdef AXI_WDATA_BEAT_CHK_EN
  logic [7:0] beat_cnt;
  logic       err_q;

  assign burst_end     = beat_cnt == head.len;
  assign bus.err_wlast = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= hs & (bus.m_wlast != burst_end);
      if (pop)
        beat_cnt <= '0;
      else if (hs)
        beat_cnt <= beat_cnt + 8'd1;
    end
  end
`else
  logic unused_len;

  assign unused_len    = ^bus.aw_len;
  assign burst_end     = bus.m_wlast;
  assign bus.err_wlast = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wdata_router.sv
// Bench for axi_wdata_router: vector table, corner sequences, random vs queue model.
`timescale 1ns/1ps
module tb_axi_wdata_router;
  import axi_route_pkg::*;

  localparam int NS    = 3;
  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int DEPTH = 4;
  localparam int SELW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_wdata_router_if #(
    .NUM_SLAVES(NS), .DATA_W(DW), .STRB_W(SW), .SEL_W(SELW)
  ) bus ();

  axi_wdata_router #(
    .NUM_SLAVES(NS), .DATA_W(DW), .STRB_W(SW),
    .DEPTH(DEPTH), .SEL_W(SELW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
  endtask

  function automatic logic [11:0] exp_strb(input int sel,
                                           input logic [3:0] strb);
    logic [11:0] r;
    r = 12'hFFF;
    if (sel < NS)
      r[sel*4 +: 4] = strb;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.aw_push  = 1'b0;
    bus.aw_sel   = '0;
    bus.aw_len   = '0;
    bus.m_wdata  = '0;
    bus.m_wstrb  = '0;
    bus.m_wlast  = 1'b0;
    bus.m_wvalid = 1'b0;
    bus.s_wready = '0;
  endtask

  task automatic push(input int sel, input int len);
    bus.aw_push = 1'b1;
    bus.aw_sel  = 2'(sel);
    bus.aw_len  = 8'(len);
    tick();
    bus.aw_push = 1'b0;
  endtask

  typedef struct {
    logic [1:0] sel;
    logic       wv;
    logic [2:0] rdy;
    logic [2:0] exp_sv;
    logic       exp_mr;
  } vec_t;

  typedef struct {
    int sel;
    int len;
  } ent_t;

  vec_t        vecs [8];
  ent_t        q [$];
  logic [31:0] rx [$];

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          order [4];
    int          pat [7];
    int          nb, stalls, pops, beat, pre;
    logic [31:0] d;
    logic [3:0]  st;
    logic [2:0]  esv;
    logic        emr, hs;
    logic [11:0] est;

    vecs[0] = '{2'd0, 1'b1, 3'b001, 3'b001, 1'b1};
    vecs[1] = '{2'd0, 1'b1, 3'b110, 3'b001, 1'b0};
    vecs[2] = '{2'd1, 1'b1, 3'b010, 3'b010, 1'b1};
    vecs[3] = '{2'd1, 1'b1, 3'b101, 3'b010, 1'b0};
    vecs[4] = '{2'd2, 1'b0, 3'b111, 3'b000, 1'b1};
    vecs[5] = '{2'd2, 1'b1, 3'b011, 3'b100, 1'b0};
    vecs[6] = '{2'd3, 1'b1, 3'b000, 3'b000, 1'b1};
    vecs[7] = '{2'd3, 1'b0, 3'b111, 3'b000, 1'b1};

    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    bus.m_wvalid = 1'b1;
    sample();
    chk("rst_mready", bus.m_wready, 1'b0);
    chk("rst_svalid", bus.s_wvalid, 3'b000);
    chk("rst_empty",  bus.route_empty, 1'b1);
    chk("rst_full",   bus.route_full, 1'b0);
    chk("rst_err",    bus.err_wlast, 1'b0);
    tick();
    idle();

    // single beat to slave 1
    push(1, 0);
    bus.m_wvalid = 1'b1;
    bus.m_wdata  = 32'hDEADBEEF;
    bus.m_wstrb  = 4'h3;
    bus.m_wlast  = 1'b1;
    bus.s_wready = 3'b010;
    sample();
    chk("beef_svalid", bus.s_wvalid, 3'b010);
    chk("beef_data",   bus.s_wdata[63:32], 32'hDEADBEEF);
    chk("beef_strb",   bus.s_wstrb, 12'hF3F);
    chk("beef_mready", bus.m_wready, 1'b1);
    chk("beef_busy",   bus.route_empty, 1'b0);
    tick();
    idle();
    sample();
    chk("beef_pop", bus.route_empty, 1'b1);
    tick();

    // routing table
    for (int i = 0; i < 8; i++) begin
      push(int'(vecs[i].sel), 0);
      d = 32'h1000_0000 + 32'(i);
      st = 4'(i + 1);
      bus.m_wvalid = vecs[i].wv;
      bus.s_wready = vecs[i].rdy;
      bus.m_wdata  = d;
      bus.m_wstrb  = st;
      bus.m_wlast  = 1'b1;
      sample();
      chk("vec_svalid", bus.s_wvalid, vecs[i].exp_sv);
      chk("vec_mready", bus.m_wready, vecs[i].exp_mr);
      chk("vec_strb", bus.s_wstrb,
          exp_strb(int'(vecs[i].sel), st));
      chk("vec_data", bus.s_wdata, {3{d}});
      chk("vec_last", bus.s_wlast, 3'b111);
      tick();
      if (!(vecs[i].wv && vecs[i].exp_mr)) begin
        bus.m_wvalid = 1'b1;
        bus.s_wready = 3'b111;
        tick();
      end
      idle();
      sample();
      chk("vec_empty", bus.route_empty, 1'b1);
      tick();
    end

    // fill, dropped fifth push, in-order drain
    order = '{0, 2, 1, 3};
    for (int i = 0; i < 4; i++)
      push(order[i], 3);
    sample();
    chk("fill_full", bus.route_full, 1'b1);
    tick();
    push(0, 3);
    sample();
    chk("fill_still_full", bus.route_full, 1'b1);
    tick();
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) begin
        bus.m_wvalid = 1'b1;
        bus.s_wready = 3'b111;
        bus.m_wdata  = 32'(b * 16 + k);
        bus.m_wlast  = (k == 3);
        sample();
        esv = (order[b] < NS) ? 3'(1 << order[b]) : 3'b000;
        chk("drain_svalid", bus.s_wvalid, esv);
        chk("drain_mready", bus.m_wready, 1'b1);
        tick();
      end
    end
    idle();
    sample();
    chk("drain_empty", bus.route_empty, 1'b1);
    tick();

    // slave 0 back-pressure mid-burst
    pat = '{1, 0, 0, 0, 1, 1, 1};
    push(0, 3);
    nb = 0;
    stalls = 0;
    rx.delete();
    for (int c = 0; c < 20 && nb < 4; c++) begin
      bus.m_wvalid = 1'b1;
      bus.m_wdata  = 32'hB0 + 32'(nb);
      bus.m_wlast  = (nb == 3);
      bus.s_wready = (c < 7) ? 3'(pat[c]) : 3'b001;
      sample();
      chk("bp_mready", bus.m_wready, bus.s_wready[0]);
      chk("bp_svalid", bus.s_wvalid, 3'b001);
      hs = bus.s_wvalid[0] & bus.s_wready[0];
      if (!bus.m_wready)
        stalls++;
      if (hs)
        rx.push_back(bus.s_wdata[31:0]);
      tick();
      if (hs)
        nb++;
    end
    idle();
    chk("bp_beats", rx.size(), 4);
    chk("bp_stalls", stalls, 3);
    for (int i = 0; i < rx.size(); i++)
      chk("bp_order", rx[i], 32'hB0 + 32'(i));
    sample();
    chk("bp_empty", bus.route_empty, 1'b1);
    tick();

    // pop+push when full, then pop+push at count 3
    for (int i = 0; i < 4; i++)
      push(0, 0);
    bus.aw_push  = 1'b1;
    bus.aw_sel   = 2'd2;
    bus.m_wvalid = 1'b1;
    bus.m_wlast  = 1'b1;
    bus.s_wready = 3'b111;
    tick();
    bus.aw_sel = 2'd0;
    tick();
    bus.aw_push  = 1'b0;
    bus.m_wvalid = 1'b0;
    sample();
    chk("pp_cnt3", bus.route_full, 1'b0);
    tick();
    push(0, 0);
    sample();
    chk("pp_full", bus.route_full, 1'b1);
    tick();
    pops = 0;
    bus.m_wvalid = 1'b1;
    for (int c = 0; c < 10 && !bus.route_empty; c++) begin
      sample();
      chk("pp_head", bus.s_wvalid, 3'b001);
      tick();
      pops++;
    end
    idle();
    chk("pp_pops", pops, 4);

`ifdef AXI_WDATA_BEAT_CHK_EN
    // early WLAST on beat 2 of a 4-beat burst
    push(1, 3);
    for (int k = 0; k < 4; k++) begin
      bus.m_wvalid = 1'b1;
      bus.s_wready = 3'b111;
      bus.m_wlast  = (k == 1 || k == 3);
      tick();
      sample();
      chk("chk_err", bus.err_wlast, 1'(k == 1));
      chk("chk_empty", bus.route_empty, 1'(k == 3));
    end
    idle();
    tick();
    sample();
    chk("chk_err_clr", bus.err_wlast, 1'b0);
    tick();
`endif

    // reset mid-burst abandons everything
    push(1, 3);
    push(2, 0);
    bus.m_wvalid = 1'b1;
    bus.s_wready = 3'b111;
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_empty",  bus.route_empty, 1'b1);
    chk("mrst_mready", bus.m_wready, 1'b0);
    chk("mrst_svalid", bus.s_wvalid, 3'b000);
    tick();
    rst = 1'b1;
    idle();
    tick();

    // random traffic against a queue model
    q.delete();
    beat = 0;
    for (int c = 0; c < 1500; c++) begin
      bus.aw_push  = ($urandom_range(0, 2) == 0);
      bus.aw_sel   = 2'($urandom_range(0, 3));
      bus.aw_len   = 8'($urandom_range(0, 3));
      bus.m_wvalid = 1'($urandom);
      bus.s_wready = 3'($urandom);
      bus.m_wdata  = $urandom;
      bus.m_wstrb  = 4'($urandom);
      if (q.size() != 0)
        bus.m_wlast = (beat == q[0].len);
      else
        bus.m_wlast = 1'($urandom);
      sample();
      esv = '0;
      emr = 1'b0;
      est = 12'hFFF;
      if (q.size() != 0) begin
        if (q[0].sel < NS) begin
          esv[q[0].sel] = bus.m_wvalid;
          emr = bus.s_wready[q[0].sel];
          est = exp_strb(q[0].sel, bus.m_wstrb);
        end else begin
          emr = 1'b1;
        end
      end
      chk("rnd_svalid", bus.s_wvalid, esv);
      chk("rnd_mready", bus.m_wready, emr);
      chk("rnd_strb",   bus.s_wstrb, est);
      chk("rnd_data",   bus.s_wdata, {3{bus.m_wdata}});
      chk("rnd_last",   bus.s_wlast, {3{bus.m_wlast}});
      chk("rnd_empty",  bus.route_empty, 1'(q.size() == 0));
      chk("rnd_full",   bus.route_full, 1'(q.size() == DEPTH));
      chk("rnd_err",    bus.err_wlast, 1'b0);
      hs = bus.m_wvalid & emr;
      pre = q.size();
      if (hs) begin
        if (beat == q[0].len) begin
          void'(q.pop_front());
          beat = 0;
        end else begin
          beat++;
        end
      end
      if (bus.aw_push && pre < DEPTH)
        q.push_back('{int'(bus.aw_sel), int'(bus.aw_len)});
      tick();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_wdata_router.md
Name: axi_wdata_router

Overview:
- Parametrised W-channel demux for one write master to NUM_SLAVES slaves plus an internal default sink.
- Holds an in-order route FIFO of AW decisions, so up to DEPTH writes can be outstanding.
- W beats go to the slave at the FIFO head. The head pops on the last beat of each burst.
- Sits in the AXI bridge between the AW decoder and the slave W ports.

Parameters:
- NUM_SLAVES, 3: number of real slave W ports.
- DATA_W, 32: WDATA width.
- STRB_W, DATA_W/8: WSTRB width.
- DEPTH, 4: route FIFO entries. Power of 2, minimum 2.
- SEL_W, $clog2(NUM_SLAVES+1): width of the slave index.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- aw_push  in  1  AW handshake completed this cycle (AWVALID&AWREADY at the master side)
- aw_sel  in  SEL_W  destination index; values >= NUM_SLAVES select the default sink
- aw_len  in  8  AWLEN of the accepted burst
- route_full  out  1  FIFO full; the AW decoder must hold AWREADY low while it is high
- route_empty  out  1  no outstanding write
- m_wdata  in  DATA_W
- m_wstrb  in  STRB_W
- m_wlast  in  1
- m_wvalid  in  1
- m_wready  out  1
- s_wdata  out  NUM_SLAVES*DATA_W  flattened, slave i at [i*DATA_W +: DATA_W]
- s_wstrb  out  NUM_SLAVES*STRB_W
- s_wlast  out  NUM_SLAVES
- s_wvalid  out  NUM_SLAVES
- s_wready  in  NUM_SLAVES
- err_wlast  out  1  one-cycle pulse on a WLAST/AWLEN mismatch (optional feature only)

Behaviour:
- Reset: FIFO pointers and count = 0, route_empty=1, route_full=0, s_wvalid=0, m_wready=0, err_wlast=0, beat counter=0.
- FIFO: registered, no bypass. An entry pushed in cycle N is at the head in cycle N+1, so W cannot complete in the same cycle as its AW.
- Push and pop:
  - Push = aw_push & !route_full.
  - aw_push while full is dropped. This is a protocol violation by the upstream logic.
  - Simultaneous push and pop when not full: count is unchanged and both pointers advance.
  - Simultaneous push and pop when full: the push is dropped, because route_full is registered from count.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- Routing when empty: every s_wvalid=0 and m_wready=0; the master waits.
- Routing, head sel=k with k<NUM_SLAVES: s_wvalid[k]=m_wvalid, all other s_wvalid=0, m_wready=s_wready[k].
- Routing, head sel>=NUM_SLAVES (default sink): all s_wvalid=0 and m_wready=1. Beats are discarded; the matching B response is produced elsewhere.
- Broadcast to every slave: s_wdata and s_wlast. s_wstrb is driven with m_wstrb on the selected slave and all-ones on every other slave.
- Beat handshake = m_wvalid & m_wready.
- Pop = handshake & burst end.
- Routing is fully combinational from the head entry and s_wready. There are no added beat-path registers.
- Reset mid-burst: the FIFO clears and any in-flight burst is abandoned; no recovery is attempted.

Optional Feature:
- Macro: AXI_WDATA_BEAT_CHK_EN.
- With the macro defined:
  - FIFO entries store {sel, len}. An 8-bit beat counter increments on each handshake and clears on pop.
  - Burst end is counter==head.len; m_wlast is ignored for the pop.
  - err_wlast pulses for one cycle on any handshake where m_wlast != (counter==head.len).
- Without the macro:
  - Entries store sel only, aw_len is unused, and there is no counter.
  - Burst end = m_wlast, and err_wlast is tied to 0.

Decomposition:
- Package axi_route_pkg holds:
  - the route_entry_t struct {sel, len}, with len present only under the macro;
  - a sel-width function;
  - the default-sink index constant.
- Sub-module axi_route_fifo: a generic DEPTH-entry synchronous FIFO of route_entry_t with full/empty flags, same clk/rst.
- The router instantiates one axi_route_fifo and adds the routing and check logic.

Test Plan:
- Reset, then m_wvalid=1 with no AW: m_wready stays 0, all s_wvalid=0, route_empty=1.
- aw_push sel=1 len=0, then a single beat 0xDEADBEEF with strb 0x3 and wlast=1, s_wready[1]=1:
  - s_wvalid=3'b010 and s_wdata slot 1=0xDEADBEEF;
  - s_wstrb is 0x3 on slave 1 and 0xF on slaves 0 and 2;
  - the entry pops and route_empty=1 on the next cycle.
- Four pushes with sels 0,2,1,3, then a fifth push:
  - route_full=1 after the fourth and the fifth push is dropped;
  - bursts of len 3 then drain in order 0,2,1 with 4 beats each;
  - sel=3 goes to the sink with m_wready=1 and no s_wvalid.
- Slave 0 back-pressure (s_wready[0]=0 for 3 cycles mid-burst): m_wready=0 for those cycles and no beat is lost or duplicated.
- Full FIFO with pop and push in the same cycle (push dropped), then count 3 with pop and push together: count stays 3.
- With AXI_WDATA_BEAT_CHK_EN defined, len=3 and wlast asserted on beat 2: err_wlast pulses for one cycle and the pop occurs after beat 4.
